ps2_mouse_ctrl: RTL and testbench
=================================

// Module: ps2_mouse_ctrl
// PURPOSE
//  Host-side PS/2 mouse controller: sequences device init (reset, self-test, enable
//  reporting), then assembles stream packets into the 25-bit ps2_mouse bus used by
//  the Kempston mouse port. Sits between the PS/2 byte serialiser and the Kempston
//  mouse block.
// PARAMETERS
//  TIMEOUT    24'd2_000_000  clk_sys cycles allowed per wait state / inter-byte gap
//  MAX_RETRY  3              full init restarts before entering FAIL
// PORTS
//  clk_sys    in   1   system clock
//  reset      in   1   synchronous, active-high
//  rx_data    in   8   byte received from mouse
//  rx_valid   in   1   one-cycle strobe, rx_data valid
//  tx_data    out  8   command byte to mouse
//  tx_req     out  1   held high, tx_data stable, until tx_done or tx_err
//  tx_done    in   1   one-cycle strobe: byte sent OK
//  tx_err     in   1   one-cycle strobe: send failed
//  ps2_mouse  out  25  [7:0] b0 (buttons/signs), [15:8] dx, [23:16] dy, [24] toggles per packet
//  wheel      out  4   last wheel delta (two's complement); 0 without MOUSE_WHEEL_EN
//  ready      out  1   high in STREAM
//  fail       out  1   high in FAIL
// BEHAVIOUR
//  - Reset: state=RST_TX, tx_req=0, tx_data=0, ps2_mouse=0, wheel=0, ready=0,
//    fail=0, retry=0, idx=0. Reset mid-transfer aborts immediately; tx_req drops
//    the following cycle.
//  - States: RST_TX(send FF) -> RST_ACK(FA) -> BAT(AA) -> ID(00) -> EN_TX(send F4)
//    -> EN_ACK(FA) -> STREAM. FAIL is terminal until reset.
//  - TX states: assert tx_req the cycle after entry; tx_done -> next state;
//    tx_err -> stay, re-send the same byte after tx_req has been low for 1 cycle.
//  - Wait states: expected byte -> next state. FE (resend) -> back to the preceding
//    TX state. Any other byte is ignored. rx_valid during TX states is ignored.
//  - Timeout: counter clears on every state entry and on every accepted rx byte.
//    Reaching TIMEOUT in a wait state restarts at RST_TX with retry+1. A timeout
//    with retry==MAX_RETRY enters FAIL. An rx_valid in the same cycle as expiry wins.
//  - Entering STREAM clears retry.
//  - STREAM: idx counts bytes 0..N-1 (N=3; 4 in wheel mode).
//    - At idx 0, a byte with bit3=0 is discarded (resync) and idx stays 0.
//    - Timeout with idx!=0 drops the partial packet (idx=0). Idle timeout at idx 0
//      has no effect.
//    - Final byte: ps2_mouse[23:0]={b2,b1,b0} and ps2_mouse[24] inverts, in the
//      cycle after that rx_valid (1-cycle latency). Partial packets never update outputs.
//    - dx/dy pass through unmodified; sign/overflow bits stay in b0.
//  - No hot-plug detection in STREAM; re-init only via reset.
// CONFIGURATION
//  MOUSE_WHEEL_EN defined:
//    - After ID, sends F3,C8,F3,64,F3,50,F2, each followed by an FA wait, then waits
//      for an ID byte. 03 -> wheel mode (N=4); any other -> N=3. Then EN_TX.
//    - In wheel mode, the 4th byte updates wheel=b3[3:0] in the same cycle as ps2_mouse.
//  MOUSE_WHEEL_EN undefined: ID goes straight to EN_TX; wheel tied 4'h0.
// TESTING
//  1. Model answers FF->FA,AA,00 and F4->FA -> ready=1 within 1 cycle of FA; retry=0.
//  2. STREAM: rx 09,05,FB -> ps2_mouse[23:0]=FB0509, bit24 inverted, next cycle.
//  3. STREAM: rx 01 (bit3=0), then 08,10,20 -> only one update, ps2_mouse[23:0]=201008.
//  4. STREAM: rx 08,10, then silence > TIMEOUT, then 08,01,02 -> single update =020108.
//  5. Mouse never answers -> after MAX_RETRY+1 timeouts, fail=1, tx_req=0; stays until reset.
//  6. Wheel build, ID reply 03: 08,01,02,0F -> ps2_mouse[23:0]=020108, wheel=F, one toggle.

Source files
------------

// File: rtl/ps2_mouse_ctrl.sv
// rtl/ps2_mouse_ctrl.sv - PS/2 mouse init sequencer and stream packet assembler (optional wheel: MOUSE_WHEEL_EN)
module ps2_mouse_ctrl #(
    parameter logic [23:0] TIMEOUT   = 24'd2_000_000,
    parameter int          MAX_RETRY = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    input  logic        tx_done,
    input  logic        tx_err,
    output logic [24:0] ps2_mouse,
    output logic [3:0]  wheel,
    output logic        ready,
    output logic        fail
);

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_RST_TX, S_RST_ACK, S_BAT, S_ID,
        S_WH_TX, S_WH_ACK, S_WH_ID,
        S_EN_TX, S_EN_ACK, S_STREAM, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   to_cnt;
    logic [RW-1:0] retry;
    logic [1:0]    idx;
    logic [1:0]    last_idx;
    logic [7:0]    b0, b1, b2_out;
    logic [7:0]    cmd;
    logic [7:0]    tx_data_q;
    logic          tx_req_q;
    logic [24:0]   ps2_q;
    logic          is_tx, is_wait, expire, wait_to, sent, tx_fail;
    logic          rx_fa, rx_fe, rx_aa, rx_00;
    logic          keep, pkt_done;
    state_t        to_target;

    assign is_tx   = (state_q == S_RST_TX) || (state_q == S_EN_TX) || (state_q == S_WH_TX);
    assign is_wait = (state_q == S_RST_ACK) || (state_q == S_BAT) || (state_q == S_ID) ||
                     (state_q == S_EN_ACK) || (state_q == S_WH_ACK) || (state_q == S_WH_ID);
    assign expire  = (to_cnt >= TIMEOUT - 24'd1);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign wait_to = is_wait && expire && !rx_valid;
    assign sent    = is_tx && tx_req_q && tx_done;
    assign tx_fail = is_tx && tx_req_q && tx_err && !tx_done;

    assign rx_fa = rx_valid && (rx_data == 8'hFA);
    assign rx_fe = rx_valid && (rx_data == 8'hFE);
    assign rx_aa = rx_valid && (rx_data == 8'hAA);
    assign rx_00 = rx_valid && (rx_data == 8'h00);

    assign to_target = (retry == RETRY_LAST) ? S_FAIL : S_RST_TX;

    // Byte 0 of a stream packet always has bit 3 set; anything else is resync noise.
    assign keep     = (state_q == S_STREAM) && rx_valid && ((idx != 2'd0) || rx_data[3]);
    assign pkt_done = keep && (idx == last_idx);

`ifdef MOUSE_WHEEL_EN
    logic [2:0] wh_idx;
    logic       wheel_mode;
    logic [7:0] b2;
    logic [3:0] wheel_q;

    assign last_idx = wheel_mode ? 2'd3 : 2'd2;
    assign b2_out   = wheel_mode ? b2 : rx_data;
    assign wheel    = wheel_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wh_idx     <= 3'd0;
            wheel_mode <= 1'b0;
            b2         <= 8'h00;
            wheel_q    <= 4'h0;
        end else begin
            if (state_q == S_ID && rx_00)
                wh_idx <= 3'd0;
            else if (state_q == S_WH_ACK && rx_fa && wh_idx != 3'd6)
                wh_idx <= wh_idx + 3'd1;
            if (state_q == S_WH_ID && rx_valid && !rx_fe)
                wheel_mode <= (rx_data == 8'h03);
            if (keep && idx == 2'd2)
                b2 <= rx_data;
            if (pkt_done && wheel_mode)
                wheel_q <= rx_data[3:0];
        end
    end
`else
    assign last_idx = 2'd2;
    assign b2_out   = rx_data;
    assign wheel    = 4'h0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset)
            state_q <= S_RST_TX;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST_TX:  if (sent) state_d = S_RST_ACK;
            S_RST_ACK: begin
                if (rx_fa)        state_d = S_BAT;
                else if (rx_fe)   state_d = S_RST_TX;
                else if (wait_to) state_d = to_target;
            end
            S_BAT: begin
                if (rx_aa)        state_d = S_ID;
                else if (rx_fe)   state_d = S_RST_TX;
                else if (wait_to) state_d = to_target;
            end
            S_ID: begin
`ifdef MOUSE_WHEEL_EN
                if (rx_00)        state_d = S_WH_TX;
`else
                if (rx_00)        state_d = S_EN_TX;
`endif
                else if (rx_fe)   state_d = S_RST_TX;
                else if (wait_to) state_d = to_target;
            end
`ifdef MOUSE_WHEEL_EN
            S_WH_TX:   if (sent) state_d = S_WH_ACK;
            S_WH_ACK: begin
                if (rx_fa)        state_d = (wh_idx == 3'd6) ? S_WH_ID : S_WH_TX;
                else if (rx_fe)   state_d = S_WH_TX;
                else if (wait_to) state_d = to_target;
            end
            S_WH_ID: begin
                if (rx_fe)         state_d = S_WH_TX;
                else if (rx_valid) state_d = S_EN_TX;
                else if (wait_to)  state_d = to_target;
            end
`endif
            S_EN_TX:   if (sent) state_d = S_EN_ACK;
            S_EN_ACK: begin
                if (rx_fa)        state_d = S_STREAM;
                else if (rx_fe)   state_d = S_EN_TX;
                else if (wait_to) state_d = to_target;
            end
            default:   state_d = state_q;
        endcase
    end

    always_comb begin
        cmd   = 8'h00;
        ready = (state_q == S_STREAM);
        fail  = (state_q == S_FAIL);
        case (state_q)
            S_RST_TX: cmd = 8'hFF;
            S_EN_TX:  cmd = 8'hF4;
`ifdef MOUSE_WHEEL_EN
            // Sample-rate knock sequence 200/100/80 unlocks the wheel ID, then read ID.
            S_WH_TX: begin
                case (wh_idx)
                    3'd0, 3'd2, 3'd4: cmd = 8'hF3;
                    3'd1:             cmd = 8'hC8;
                    3'd3:             cmd = 8'h64;
                    3'd5:             cmd = 8'h50;
                    default:          cmd = 8'hF2;
                endcase
            end
`endif
            default:  cmd = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
            to_cnt    <= 24'd0;
            retry     <= '0;
            idx       <= 2'd0;
            b0        <= 8'h00;
            b1        <= 8'h00;
            ps2_q     <= 25'd0;
        end else begin
            // After a failed send tx_req stays low one cycle before the retry.
            if (!is_tx || sent || tx_fail)
                tx_req_q <= 1'b0;
            else if (!tx_req_q) begin
                tx_req_q  <= 1'b1;
                tx_data_q <= cmd;
            end

            if (state_d != state_q || keep || !(is_wait || state_q == S_STREAM))
                to_cnt <= 24'd0;
            else if (state_q == S_STREAM && expire)
                to_cnt <= 24'd0;
            else if (!expire)
                to_cnt <= to_cnt + 24'd1;

            if (state_d == S_STREAM && state_q != S_STREAM)
                retry <= '0;
            else if (wait_to && retry != RETRY_LAST)
                retry <= retry + 1'b1;

            if (keep) begin
                if (idx == 2'd0) b0 <= rx_data;
                if (idx == 2'd1) b1 <= rx_data;
                idx <= pkt_done ? 2'd0 : idx + 2'd1;
            end else if (state_q == S_STREAM && expire) begin
                idx <= 2'd0;
            end

            if (pkt_done)
                ps2_q <= {~ps2_q[24], b2_out, b1, b0};
        end
    end

    assign tx_req    = tx_req_q;
    assign tx_data   = tx_data_q;
    assign ps2_mouse = ps2_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb/tb_ps2_mouse_ctrl.sv - self-checking bench for ps2_mouse_ctrl with mouse/serialiser model
module tb_ps2_mouse_ctrl;

    localparam logic [23:0] TO = 24'd200;
    localparam int          MR = 3;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_done = 1'b0;
    logic        tx_err  = 1'b0;
    logic [24:0] ps2_mouse;
    logic [3:0]  wheel;
    logic        ready, fail;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int last_rx_cyc = 0;
    int rx_gap = 0;
    int tx_wait = 0;
    int err_budget = 0;
    bit auto_reply = 1'b0;
    bit fe_on_f4 = 1'b0;
    bit tx_hold = 1'b0;
    logic [7:0] wheel_id_byte = 8'h00;

    int         rx_q[$];
    logic [7:0] sent_log[$];
    logic [7:0] exp_cmds[$];

    logic [7:0]  pend[$];
    logic [24:0] exp_ps2 = 25'd0;
    logic [3:0]  exp_wheel = 4'h0;
    int          n_len = 3;

    ps2_mouse_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk_sys(clk_sys), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_mouse(ps2_mouse), .wheel(wheel), .ready(ready), .fail(fail)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Mouse side: every command answered after at least one idle cycle (-1 = idle slot).
    task automatic respond(input logic [7:0] c);
        if (!auto_reply) return;
        rx_q.push_back(-1);
        if (c == 8'hF4 && fe_on_f4) begin
            fe_on_f4 = 1'b0;
            rx_q.push_back(32'hFE);
        end else if (c == 8'hFF) begin
            rx_q.push_back(32'h5A);
            rx_q.push_back(32'hFA);
            rx_q.push_back(32'hAA);
            rx_q.push_back(32'h00);
        end else if (c == 8'hF2) begin
            rx_q.push_back(32'hFA);
            rx_q.push_back(int'(wheel_id_byte));
        end else begin
            rx_q.push_back(32'hFA);
        end
    endtask

    initial forever begin
        @(negedge clk_sys);
        if (reset) begin
            tx_wait = 0; tx_done = 1'b0; tx_err = 1'b0;
        end else if (tx_done || tx_err) begin
            tx_done = 1'b0; tx_err = 1'b0;
        end else if (tx_req && !tx_hold) begin
            if (tx_wait == 0) tx_wait = $urandom_range(1, 4);
            else begin
                tx_wait--;
                if (tx_wait == 0) begin
                    sent_log.push_back(tx_data);
                    if (err_budget > 0) begin
                        err_budget--; tx_err = 1'b1;
                    end else begin
                        tx_done = 1'b1; respond(tx_data);
                    end
                end
            end
        end
    end

    initial forever begin : rx_driver
        int v;
        @(negedge clk_sys);
        if (rx_valid) begin
            rx_valid = 1'b0; rx_cnt++; rx_gap = $urandom_range(0, 3);
        end else if (rx_gap > 0) begin
            rx_gap--;
        end else if (rx_q.size() > 0) begin
            v = rx_q.pop_front();
            if (v >= 0) begin
                rx_data = 8'(v); rx_valid = 1'b1; last_rx_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        rx_q.delete(); pend.delete();
        exp_ps2 = 25'd0; exp_wheel = 4'h0;
        err_budget = 0; fe_on_f4 = 1'b0;
        repeat (3) @(negedge clk_sys);
        sent_log.delete();
        reset = 1'b0;
    endtask

    task automatic build_cmds(input bit with_err, input bit with_fe);
        exp_cmds.delete();
        exp_cmds.push_back(8'hFF);
        if (with_err) exp_cmds.push_back(8'hFF);
`ifdef MOUSE_WHEEL_EN
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'hC8);
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'h64);
        exp_cmds.push_back(8'hF3); exp_cmds.push_back(8'h50);
        exp_cmds.push_back(8'hF2);
`endif
        exp_cmds.push_back(8'hF4);
        if (with_fe) exp_cmds.push_back(8'hF4);
    endtask

    task automatic wait_ready(output bit got, output int seen);
        got = 1'b0; seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys); #1;
            if (ready) begin got = 1'b1; seen = cyc; break; end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int target;
        rx_q.push_back(int'(b));
        target = rx_cnt + 1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys); #1;
            if (rx_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    // Packet rules: resync until a bit3=1 first byte, then N bytes form one report.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] last;
        if (pend.size() == 0 && b[3] == 1'b0) return;
        pend.push_back(b);
        if (pend.size() == n_len) begin
            exp_ps2 = {~exp_ps2[24], pend[2], pend[1], pend[0]};
            if (n_len == 4) begin
                last = pend[3];
                exp_wheel = last[3:0];
            end
            pend.delete();
        end
    endtask

    task automatic test_reset();
        tx_hold = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys); #1;
        n_cmp++;
        if (tx_req !== 1'b0 || tx_data !== 8'h00 || ps2_mouse !== 25'd0 || wheel !== 4'h0 ||
            ready !== 1'b0 || fail !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: tx_req=%b tx_data=%h ps2=%h wheel=%h ready=%b fail=%b, required all zero",
                     tx_req, tx_data, ps2_mouse, wheel, ready, fail);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_sys); #1;
        n_cmp++;
        if (tx_req !== 1'b1 || tx_data !== 8'hFF) begin
            n_bad++;
            $display("FAIL first_cmd: tx_req=%b tx_data=%h, required 1 FF", tx_req, tx_data);
        end
        reset = 1'b1;
        @(negedge clk_sys); #1;
        n_cmp++;
        if (tx_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_tx: tx_req=%b, required 0", tx_req);
        end
        tx_hold = 1'b0;
    endtask

    task automatic check_init(input bit with_err, input bit with_fe);
        bit got; int seen; bit same;
        do_reset();
        if (with_err) err_budget = 1;
        fe_on_f4 = with_fe;
        wait_ready(got, seen);
        n_cmp++;
        if (!got || fail !== 1'b0) begin
            n_bad++;
            $display("FAIL init_ready: ready=%b fail=%b, required 1 0", ready, fail);
        end
        n_cmp++;
        if (seen != last_rx_cyc + 1) begin
            n_bad++;
            $display("FAIL ready_latency: ready at cycle %0d, required %0d", seen, last_rx_cyc + 1);
        end
        build_cmds(with_err, with_fe);
        same = (sent_log.size() == exp_cmds.size());
        for (int i = 0; same && i < exp_cmds.size(); i++)
            if (sent_log[i] !== exp_cmds[i]) same = 1'b0;
        n_cmp++;
        if (!same) begin
            n_bad++;
            $display("FAIL init_cmds: %0d bytes sent (first %h), required %0d bytes",
                     sent_log.size(), (sent_log.size() > 0) ? sent_log[0] : 8'h00, exp_cmds.size());
        end
        n_len = 3;
    endtask

    task automatic test_init();
        auto_reply = 1'b1;
        wheel_id_byte = 8'h00;
        check_init(1'b0, 1'b0);
    endtask

    task automatic test_init_recover();
        check_init(1'b1, 1'b1);
    endtask

    task automatic test_stream_spec();
        int seq[$];
        bit ok;
        seq = '{32'h09, 32'h05, 32'hFB, 32'h01, 32'h08, 32'h10, 32'h20,
                32'h08, 32'h10, -1, 32'h08, 32'h01, 32'h02};
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] < 0) begin
                repeat (int'(TO) + 30) @(negedge clk_sys);
                pend.delete();
                ok = 1'b1;
            end else begin
                send_byte(8'(seq[i]), ok);
                model_byte(8'(seq[i]));
            end
            n_cmp++;
            if (!ok || ps2_mouse !== exp_ps2 || wheel !== exp_wheel) begin
                n_bad++;
                $display("FAIL stream_spec[%0d]: ps2=%h wheel=%h ok=%b, required ps2=%h wheel=%h",
                         i, ps2_mouse, wheel, ok, exp_ps2, exp_wheel);
            end
            if (i == 2 || i == 6 || i == 12) begin
                n_cmp++;
                if (ps2_mouse[23:0] !== ((i == 2) ? 24'hFB0509 : (i == 6) ? 24'h201008 : 24'h020108)) begin
                    n_bad++;
                    $display("FAIL stream_const[%0d]: ps2[23:0]=%h", i, ps2_mouse[23:0]);
                end
            end
        end
    endtask

    task automatic test_stream_random();
        int seq[$];
        bit ok;
        for (int p = 0; p < 40; p++) begin
            repeat ($urandom_range(0, 2)) seq.push_back(int'($urandom_range(0, 255) & 32'hF7));
            if ($urandom_range(0, 7) == 0) begin
                seq.push_back(int'($urandom_range(0, 255) | 32'h08));
                if ($urandom_range(0, 1) == 1) seq.push_back(int'($urandom_range(0, 255)));
                seq.push_back(-1);
            end
            seq.push_back(int'($urandom_range(0, 255) | 32'h08));
            for (int k = 1; k < n_len; k++) seq.push_back(int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] < 0) begin
                repeat (int'(TO) + 30) @(negedge clk_sys);
                pend.delete();
                ok = 1'b1;
            end else begin
                send_byte(8'(seq[i]), ok);
                model_byte(8'(seq[i]));
            end
            n_cmp++;
            if (!ok || ps2_mouse !== exp_ps2 || wheel !== exp_wheel) begin
                n_bad++;
                $display("FAIL stream_rand[%0d]: ps2=%h wheel=%h ok=%b, required ps2=%h wheel=%h",
                         i, ps2_mouse, wheel, ok, exp_ps2, exp_wheel);
            end
        end
    endtask

    task automatic test_fail();
        int start, took;
        bit got;
        auto_reply = 1'b0;
        do_reset();
        start = cyc; got = 1'b0; took = 0;
        for (int i = 0; i < 8 * int'(TO); i++) begin
            @(negedge clk_sys); #1;
            if (fail) begin got = 1'b1; took = cyc - start; break; end
        end
        n_cmp++;
        if (!got || tx_req !== 1'b0 || ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_enter: fail=%b tx_req=%b ready=%b, required 1 0 0", fail, tx_req, ready);
        end
        n_cmp++;
        if (took < (MR + 1) * int'(TO) || sent_log.size() != MR + 1) begin
            n_bad++;
            $display("FAIL fail_retries: %0d cycles, %0d resets sent, required >=%0d cycles and %0d sends",
                     took, sent_log.size(), (MR + 1) * int'(TO), MR + 1);
        end
        repeat (2 * int'(TO)) @(negedge clk_sys); #1;
        n_cmp++;
        if (fail !== 1'b1 || tx_req !== 1'b0 || sent_log.size() != MR + 1) begin
            n_bad++;
            $display("FAIL fail_sticky: fail=%b tx_req=%b sends=%0d, required 1 0 %0d",
                     fail, tx_req, sent_log.size(), MR + 1);
        end
        auto_reply = 1'b1;
    endtask

`ifdef MOUSE_WHEEL_EN
    task automatic test_wheel();
        bit got; int seen; bit ok;
        logic [7:0] bytes[4];
        logic t0;
        wheel_id_byte = 8'h03;
        do_reset();
        wait_ready(got, seen);
        n_len = 4;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL wheel_init: ready=%b, required 1", ready);
        end
        bytes = '{8'h08, 8'h01, 8'h02, 8'h0F};
        t0 = ps2_mouse[24];
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ok);
            model_byte(bytes[i]);
            n_cmp++;
            if (!ok || ps2_mouse !== exp_ps2 || wheel !== exp_wheel) begin
                n_bad++;
                $display("FAIL wheel_byte[%0d]: ps2=%h wheel=%h, required ps2=%h wheel=%h",
                         i, ps2_mouse, wheel, exp_ps2, exp_wheel);
            end
        end
        n_cmp++;
        if (ps2_mouse[23:0] !== 24'h020108 || wheel !== 4'hF || ps2_mouse[24] !== ~t0) begin
            n_bad++;
            $display("FAIL wheel_const: ps2=%h wheel=%h, required 020108 F toggled", ps2_mouse, wheel);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_stream_spec();
        test_stream_random();
        test_init_recover();
        test_stream_random();
        test_fail();
`ifdef MOUSE_WHEEL_EN
        test_wheel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
